// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-outstanding initiator for the simple register bus
// Optional low-region write protection is enabled by defining REG_MST_WPROT_EN.
module reg_bus_master #(
   parameter int          ADDR_WIDTH = 24,
   parameter int unsigned WP_LIMIT   = 'h100
) (
   input  logic                  reg_clk,
   input  logic                  reg_rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdat,
   input  logic [3:0]            cmd_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdat,
   output logic                  rsp_err,
   output logic                  reg_wr,
   output logic                  reg_rd,
   output logic [3:0]            reg_we,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [31:0]           reg_wdat,
   input  logic [31:0]           reg_rdat,
   input  logic                  wp_dis
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WSTB = 3'd1;
   localparam logic [2:0] S_RSTB = 3'd2;
   localparam logic [2:0] S_RCAP = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] LP_WP_LIMIT = ADDR_WIDTH'(WP_LIMIT);

   logic [2:0]            r_state;
   logic                  r_wr;
   logic                  r_rd;
   logic [3:0]            r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdat;
   logic                  r_rsp_valid;
   logic [31:0]           r_rsp_rdat;
   logic                  r_rsp_err;
   logic                  w_wp_block;

`ifdef REG_MST_WPROT_EN
   assign w_wp_block = cmd_write && (cmd_addr < LP_WP_LIMIT) && !wp_dis;
`else
   logic w_unused_wp;
   assign w_wp_block  = 1'b0;
   assign w_unused_wp = wp_dis ^ (|LP_WP_LIMIT);
`endif

   // Gated by reset so the host sees no ready while the block is held in reset.
   assign cmd_ready = reg_rstn && (r_state == S_IDLE);

   always_ff @(posedge reg_clk or negedge reg_rstn) begin
      if (!reg_rstn) begin
         r_state     <= S_IDLE;
         r_wr        <= 1'b0;
         r_rd        <= 1'b0;
         r_we        <= 4'b0;
         r_addr      <= '0;
         r_wdat      <= 32'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdat  <= 32'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         r_rd <= 1'b0;
         r_we <= 4'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr <= cmd_addr;
                  r_wdat <= cmd_wdat;
                  if (!cmd_write) begin
                     r_state <= S_RSTB;
                     r_rd    <= 1'b1;
                  end else if (w_wp_block) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_rdat  <= 32'b0;
                     r_rsp_err   <= 1'b1;
                  end else begin
                     r_state <= S_WSTB;
                     r_wr    <= 1'b1;
                     r_we    <= cmd_be;
                  end
               end
            end
            S_WSTB: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_rdat  <= 32'b0;
               r_rsp_err   <= 1'b0;
            end
            S_RSTB: begin
               r_state <= S_RCAP;
            end
            // Responders present registered data in the cycle after the read strobe.
            S_RCAP: begin
               r_state     <= S_RESP;
               r_rsp_valid <= 1'b1;
               r_rsp_rdat  <= reg_rdat;
               r_rsp_err   <= 1'b0;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdat  <= 32'b0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign reg_wr    = r_wr;
   assign reg_rd    = r_rd;
   assign reg_we    = r_we;
   assign reg_addr  = r_addr;
   assign reg_wdat  = r_wdat;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdat  = r_rsp_rdat;
   assign rsp_err   = r_rsp_err;

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
- Initiator for the team's simple register bus (reg_wr/reg_rd/reg_we/reg_addr/reg_wdat/reg_rdat) used by every generated *_reg block.
- Accepts one command at a time on a valid/ready request channel, issues a single-cycle write or read strobe, captures registered read data and returns a response on a valid/ready response channel.
- Sits between a host bridge (CPU/JTAG/UART) and the register-file fabric.

Parameters:
- ADDR_WIDTH, 24, width of cmd_addr and reg_addr.
- WP_LIMIT, 'h100, protected region is addresses < WP_LIMIT (used only with REG_MST_WPROT_EN).

Ports:
- reg_clk  input  1  clock
- reg_rstn  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  ADDR_WIDTH  target address
- cmd_wdat  input  32  write data
- cmd_be  input  4  byte enables for write
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready
- rsp_rdat  output  32  read data (0 for writes)
- rsp_err  output  1  command rejected (write-protect), else 0
- reg_wr  output  1  write strobe, one cycle
- reg_rd  output  1  read strobe, one cycle
- reg_we  output  4  byte write enables
- reg_addr  output  ADDR_WIDTH  bus address
- reg_wdat  output  32  bus write data
- reg_rdat  input  32  registered read data from responders (valid cycle after reg_rd)
- wp_dis  input  1  write-protect disable

Behaviour:
- Reset: state IDLE; cmd_ready=0 during reset, 1 in IDLE after reset; rsp_valid=0, rsp_rdat=0, rsp_err=0, reg_wr=0, reg_rd=0, reg_we=0, reg_addr=0, reg_wdat=0.
- FSM states: IDLE, WSTB, RSTB, RCAP, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch cmd_write/addr/wdat/be into reg_addr/reg_wdat and internal regs; go to WSTB if write, RSTB if read.
- WSTB: reg_wr=1, reg_we=latched be, exactly one cycle -> RESP; rsp_rdat=0, rsp_err=0.
- RSTB: reg_rd=1, reg_we=0, one cycle -> RCAP.
- RCAP: strobes low; sample reg_rdat at end of this cycle into rsp_rdat -> RESP.
- RESP: rsp_valid=1, rsp_rdat/rsp_err stable; on rsp_ready -> IDLE (rsp_valid low next cycle, rsp_rdat/rsp_err cleared to 0).
- Latency from accept edge: write rsp_valid 2 cycles later; read rsp_valid 3 cycles later. Max throughput: write 1 per 3 cycles, read 1 per 4, given rsp_ready held high.
- cmd_ready is 0 in every non-IDLE state; cmd inputs ignored there.
- reg_wr and reg_rd never high simultaneously; each high for exactly one cycle per command.
- reg_we=0 whenever reg_wr=0. reg_addr/reg_wdat hold last command value between commands.
- cmd_be=0 write: still issues reg_wr with reg_we=0, normal response.
- Back-pressure: rsp_valid held indefinitely until rsp_ready; no new command accepted.
- Async reset mid-transaction: all outputs to reset values immediately; in-flight command is dropped, no response.

Optional Feature:
- Macro REG_MST_WPROT_EN.
- Defined: a write with cmd_addr < WP_LIMIT while wp_dis=0 (sampled at accept) skips WSTB: no reg_wr pulse; goes IDLE->RESP directly with rsp_err=1, rsp_rdat=0 (latency 1 cycle). Reads are never blocked. wp_dis=1 disables the check.
- Not defined: wp_dis ignored, rsp_err tied 0, all writes issued.

Test Plan:
- Reset, then write addr 'h8 data 'h0000_1E02 be 'b0011, rsp_ready=1 -> one reg_wr pulse with reg_we='b0011, reg_addr='h8, reg_wdat='h1E02; rsp_valid 2 cycles after accept, rsp_err=0.
- Read addr 'h0, model returns 'h0000_0102 on reg_rdat cycle after reg_rd -> one reg_rd pulse, rsp_rdat='h102 3 cycles after accept; reg_wr never high.
- Read with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdat stable, cmd_ready=0 throughout; accepted in IDLE on cycle after rsp_ready=1.
- Back-to-back commands with cmd_valid held high (W,R,W) -> exactly three strobes in order, no overlap, cmd_ready only high in IDLE.
- Assert reg_rstn low during RSTB -> reg_rd drops immediately, no rsp_valid after reset release, cmd_ready=1 first cycle after release.
- REG_MST_WPROT_EN, WP_LIMIT='h100: write 'h40 wp_dis=0 -> no reg_wr, rsp_err=1 next cycle; same with wp_dis=1 -> reg_wr pulse, rsp_err=0; write 'h100 wp_dis=0 -> issued.
